// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with trap, redirect, alignment check and return-address stack
module pc_sequencer #(
    parameter int unsigned          WORD_LEN     = 32,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter logic [WORD_LEN-1:0]  RESET_VECTOR = '0,
    parameter logic [WORD_LEN-1:0]  TRAP_VECTOR  = WORD_LEN'('h80),
    parameter int unsigned          RAS_DEPTH    = 4,
    localparam int unsigned         PW           = $clog2(RAS_DEPTH),
    localparam int unsigned         CW           = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                trap,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_target,
    input  logic                call,
    input  logic                ret,
    output logic [WORD_LEN-1:0] pc,
    output logic [WORD_LEN-1:0] pc_plus,
    output logic                misalign_fault,
    output logic [CW-1:0]       ras_count
);
    logic [WORD_LEN-1:0]                pc_q, pc_d;
    logic                               fault_q, fault_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic [PW-1:0]                      sp_q, sp_d, sp_inc;
    logic [RAS_DEPTH-1:0][WORD_LEN-1:0] ras_q, ras_d;
    logic                               misaligned;
    assign pc_plus        = pc_q + WORD_LEN'(INSTR_BYTES);
    assign sp_inc         = sp_q + PW'(1);
    assign misaligned     = (redirect_target & WORD_LEN'(INSTR_BYTES - 1)) != '0;
    assign pc             = pc_q;
    assign misalign_fault = fault_q;
    assign ras_count      = cnt_q;
    // next-state selection: trap > stall > ret > redirect > sequential step
    always_comb begin
        pc_d    = pc_q;
        fault_d = 1'b0;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        ras_d   = ras_q;
        if (trap) begin
            pc_d = TRAP_VECTOR;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            pc_d  = (cnt_q != '0) ? ras_q[sp_q] : pc_plus;
            sp_d  = (cnt_q != '0) ? sp_q - PW'(1) : sp_q;
            cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        end else if (redirect_valid && misaligned) begin
            pc_d    = TRAP_VECTOR;
            fault_d = 1'b1;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
            if (call) begin
                sp_d          = sp_inc;
                ras_d[sp_inc] = pc_plus;
                cnt_d         = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
            end
        end else begin
            pc_d = pc_plus;
        end
    end
    // state registers; reset clears the stack so the first return after it falls through
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            sp_q    <= '0;
            ras_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            ras_q   <= ras_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed check of pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        misalign_fault;
    logic [2:0]  ras_count;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct packed {
        logic        rs;
        logic        st;
        logic        tr;
        logic        rv;
        logic [31:0] tg;
        logic        cl;
        logic        rt;
        logic [31:0] pc;
        logic        f;
        logic [2:0]  c;
    } vec_t;

    vec_t tbl[$];

    pc_sequencer dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .trap(trap),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .call(call),
        .ret(ret),
        .pc(pc),
        .pc_plus(pc_plus),
        .misalign_fault(misalign_fault),
        .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, st, tr, rv, input logic [31:0] tg,
                                input logic cl, rt, input logic [31:0] p, input logic f,
                                input logic [2:0] c);
        vec_t v;
        v.rs = rs; v.st = st; v.tr = tr; v.rv = rv; v.tg = tg;
        v.cl = cl; v.rt = rt; v.pc = p; v.f = f; v.c = c;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rs; stall = v.st; trap = v.tr; redirect_valid = v.rv;
        redirect_target = v.tg; call = v.cl; ret = v.rt;
        @(posedge clk);
        #1;
        n_vec++;
        check("pc", idx, pc, v.pc);
        check("pc_plus", idx, pc_plus, v.pc + 32'd4);
        check("misalign_fault", idx, {31'b0, misalign_fault}, {31'b0, v.f});
        check("ras_count", idx, {29'b0, ras_count}, {29'b0, v.c});
    endtask

    initial begin
        //                rs st tr rv tgt           cl rt pc            f  cnt
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,      0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h4,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h8,      0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h8,      0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h40,       1, 0, 32'h8,      0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 1, 32'h8,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'hC,      0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h4,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h8,      0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h100,      1, 0, 32'h100,    0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'hC,      0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h200,      1, 0, 32'h200,    0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h102,      1, 0, 32'h80,     1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h84,     0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h80,     0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h10,     0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h301,      0, 0, 32'h80,     1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h303,      0, 0, 32'h80,     1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h84,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h4,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h8,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'hC,      0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h1C,       1, 0, 32'h1C,     0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h2C,       1, 0, 32'h2C,     0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h3C,       1, 0, 32'h3C,     0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 32'h4C,       1, 0, 32'h4C,     0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 32'h300,      1, 0, 32'h300,    0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h50,     0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h40,     0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h30,     0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h20,     0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h500,      1, 1, 32'h24,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h28,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h2C,     0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        // wrap of pc_plus at the top of the address space
        apply(mk(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 0), 100);
        apply(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0), 101);
        // reset beats trap and ret, and discards the stacked return
        apply(mk(0, 0, 0, 1, 32'h400,      1, 0, 32'h400,      0, 1), 102);
        apply(mk(0, 0, 0, 1, 32'h600,      1, 0, 32'h600,      0, 2), 103);
        apply(mk(1, 0, 1, 0, 32'h0,        0, 1, 32'h0,        0, 0), 104);
        apply(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h4,        0, 0), 105);
        // trap while a stacked return is pending leaves the stack intact
        apply(mk(0, 0, 0, 1, 32'h700,      1, 0, 32'h700,      0, 1), 106);
        apply(mk(0, 0, 1, 1, 32'h900,      1, 1, 32'h80,       0, 1), 107);
        apply(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h8,        0, 0), 108);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
